sbus_block_allocator: RTL and testbench

Simple-bus slave that manages dynamic allocation of a fixed pool of on-chip storage blocks. It consumes the 16-bit simple bus (valid/op/addr/wr_data, registered rd_data) produced by the bus BFM or master. Software allocates blocks by reading a pop register and releases them by writing a push register. A free-list FIFO and an allocated bitmap catch range and double-free errors.

---
 rtl/sbus_block_allocator_pkg.sv | 27 ++
 rtl/sbus_block_allocator_blk_free_fifo.sv | 64 ++++++
 rtl/sbus_block_allocator.sv | 134 +++++++++++++
 tb/tb_sbus_block_allocator.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/sbus_block_allocator_pkg.sv
// Shared definitions for the block allocator: bus op encoding, register map,
// STATUS bit positions and the ID constant.
package sbus_block_allocator_pkg;

    typedef enum logic {
        bus_rd = 1'b0,
        bus_wr = 1'b1
    } bus_op_t;

    // Register map (byte addresses)
    localparam logic [15:0] ALLOC_ADDR    = 16'h0000;
    localparam logic [15:0] FREE_ADDR     = 16'h0002;
    localparam logic [15:0] FREE_CNT_ADDR = 16'h0004;
    localparam logic [15:0] STATUS_ADDR   = 16'h0006;
    localparam logic [15:0] ALLOC_MAP_ADDR = 16'h0008;
    localparam logic [15:0] ID_ADDR       = 16'h000A;

    // STATUS bit positions
    localparam int ST_EMPTY     = 0;
    localparam int ST_ALL_FREE  = 1;
    localparam int ST_ERR_DFREE = 2;
    localparam int ST_ERR_RANGE = 3;
    localparam int ST_ERR_EMPTY = 4;

    localparam logic [15:0] ID_VALUE = 16'hA10C;

endpackage

// File: rtl/sbus_block_allocator_blk_free_fifo.sv
// Free-list FIFO. Comes out of reset full, holding 0..DEPTH-1 in order, so the
// first pops hand out indices in ascending order. Pointers wrap modulo DEPTH,
// which need not be a power of two.
module blk_free_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Head entry is presented combinationally so the bus can register it on the popping edge
    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

    // Next-state for pointers and occupancy, wrapping at DEPTH-1
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == WIDTH'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push) begin
            wr_ptr_d = (wr_ptr_q == WIDTH'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Storage and pointer registers; reset preloads the identity sequence
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= WIDTH'(i);
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= CNT_W'(DEPTH);
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/sbus_block_allocator.sv
// Simple-bus slave handing out storage block indices. Reading ALLOC pops the
// free list, writing FREE returns an index. The allocated bitmap rejects
// out-of-range and double frees; errors are sticky in STATUS and drive irq.
module sbus_block_allocator
    import sbus_block_allocator_pkg::*;
#(
    parameter int NUM_BLOCKS = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        bus_valid,
    input  logic        bus_op,
    input  logic [15:0] bus_addr,
    input  logic [15:0] bus_wr_data,
    output logic [15:0] bus_rd_data,
    output logic        alloc_empty,
    output logic        irq
);

    localparam int IDX_W = $clog2(NUM_BLOCKS);
    localparam int CNT_W = $clog2(NUM_BLOCKS + 1);

    logic [15:0]           rd_data_q, rd_data_d;
    logic [NUM_BLOCKS-1:0] bitmap_q, bitmap_d;
    logic [ST_ERR_EMPTY:ST_ERR_DFREE] err_q, err_d, err_set, err_clr;

    logic             acc_rd, acc_wr;
    logic             fifo_pop, fifo_push;
    logic [IDX_W-1:0] pop_idx;
    logic [IDX_W-1:0] free_idx;
    logic [CNT_W-1:0] free_cnt;
    logic             free_in_range;
    logic             cnt_zero, cnt_full;
    logic [15:0]      status_val;

    blk_free_fifo #(
        .DEPTH (NUM_BLOCKS),
        .WIDTH (IDX_W)
    ) u_free_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (free_idx),
        .pop       (fifo_pop),
        .pop_data  (pop_idx),
        .count     (free_cnt)
    );

    assign cnt_zero      = (free_cnt == '0);
    assign cnt_full      = (free_cnt == CNT_W'(NUM_BLOCKS));
    assign free_idx      = bus_wr_data[IDX_W-1:0];
    assign free_in_range = (bus_wr_data < 16'(NUM_BLOCKS));

    assign acc_rd = bus_valid && (bus_op_t'(bus_op) == bus_rd);
    assign acc_wr = bus_valid && (bus_op_t'(bus_op) == bus_wr);

    // Both outputs come from registered state only
    assign alloc_empty = cnt_zero;
    assign irq         = |err_q;

    // STATUS read view
    always_comb begin
        status_val                = '0;
        status_val[ST_EMPTY]      = cnt_zero;
        status_val[ST_ALL_FREE]   = cnt_full;
        status_val[ST_ERR_DFREE]  = err_q[ST_ERR_DFREE];
        status_val[ST_ERR_RANGE]  = err_q[ST_ERR_RANGE];
        status_val[ST_ERR_EMPTY]  = err_q[ST_ERR_EMPTY];
    end

    // Address decode, side effects and read-data selection
    always_comb begin
        rd_data_d = rd_data_q;
        bitmap_d  = bitmap_q;
        err_set   = '0;
        err_clr   = '0;
        fifo_pop  = 1'b0;
        fifo_push = 1'b0;

        if (acc_rd) begin
            unique case (bus_addr)
                ALLOC_ADDR: begin
                    if (!cnt_zero) begin
                        fifo_pop          = 1'b1;
                        rd_data_d         = 16'h8000 | 16'(pop_idx);
                        bitmap_d[pop_idx] = 1'b1;
                    end else begin
                        rd_data_d             = 16'h0000;
                        err_set[ST_ERR_EMPTY] = 1'b1;
                    end
                end
                FREE_CNT_ADDR:  rd_data_d = 16'(free_cnt);
                STATUS_ADDR:    rd_data_d = status_val;
                ALLOC_MAP_ADDR: rd_data_d = 16'(bitmap_q);
                ID_ADDR:        rd_data_d = ID_VALUE;
                default:        rd_data_d = 16'h0000;
            endcase
        end

        if (acc_wr) begin
            if (bus_addr == FREE_ADDR) begin
                if (!free_in_range) begin
                    err_set[ST_ERR_RANGE] = 1'b1;
                end else if (!bitmap_q[free_idx]) begin
                    err_set[ST_ERR_DFREE] = 1'b1;
                end else begin
                    fifo_push          = 1'b1;
                    bitmap_d[free_idx] = 1'b0;
                end
            end else if (bus_addr == STATUS_ADDR) begin
                err_clr = bus_wr_data[ST_ERR_EMPTY:ST_ERR_DFREE];
            end
        end

        // A new error wins over a same-cycle clear
        err_d = (err_q & ~err_clr) | err_set;
    end

    // Bus-visible state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q <= '0;
            bitmap_q  <= '0;
            err_q     <= '0;
        end else begin
            rd_data_q <= rd_data_d;
            bitmap_q  <= bitmap_d;
            err_q     <= err_d;
        end
    end

    assign bus_rd_data = rd_data_q;

endmodule

// File: tb/tb_sbus_block_allocator.sv
// Bench for the block allocator: a 16-block instance walks the directed
// register scenarios, a 12-block instance runs a randomized alloc/free stream
// against a free-list model, with a reset in the middle.
module tb_sbus_block_allocator;
    import sbus_block_allocator_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst16_n, v16, op16, ae16, irq16;
    logic [15:0] a16, d16, rd16;
    logic        rst12_n, v12, op12, ae12, irq12;
    logic [15:0] a12, d12, rd12;

    sbus_block_allocator #(.NUM_BLOCKS(16)) u_dut16 (
        .clk(clk), .reset_n(rst16_n), .bus_valid(v16), .bus_op(op16),
        .bus_addr(a16), .bus_wr_data(d16), .bus_rd_data(rd16),
        .alloc_empty(ae16), .irq(irq16)
    );

    sbus_block_allocator #(.NUM_BLOCKS(12)) u_dut12 (
        .clk(clk), .reset_n(rst12_n), .bus_valid(v12), .bus_op(op12),
        .bus_addr(a12), .bus_wr_data(d12), .bus_rd_data(rd12),
        .alloc_empty(ae12), .irq(irq12)
    );

    int n_total = 0;
    int n_bad   = 0;
    logic [15:0] exp_q [$];

    // 12-block reference model
    int          fq [$];
    logic [11:0] map12;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%04h want=%04h", tag, got, want);
        end
    endtask

    // One bus transaction; reads queue their expectation and compare one edge later
    task automatic xfer(input bit sel12, input bit wr, input logic [15:0] addr,
                        input logic [15:0] data, input logic [15:0] want, input string tag);
        logic [15:0] e;
        logic [15:0] got;
        @(negedge clk);
        if (sel12) begin
            v12 = 1'b1; op12 = wr; a12 = addr; d12 = data;
        end else begin
            v16 = 1'b1; op16 = wr; a16 = addr; d16 = data;
        end
        if (!wr) exp_q.push_back(want);
        @(posedge clk);
        #1;
        if (!wr) begin
            e   = exp_q.pop_front();
            got = sel12 ? rd12 : rd16;
            chk(tag, got, e);
            $display("txn dut%0d rd addr=%04h data=%04h", sel12 ? 12 : 16, addr, got);
        end else begin
            $display("txn dut%0d wr addr=%04h data=%04h", sel12 ? 12 : 16, addr, data);
        end
    endtask

    task automatic idle(input bit sel12);
        @(negedge clk);
        if (sel12) v12 = 1'b0; else v16 = 1'b0;
    endtask

    task automatic model12_reset();
        fq.delete();
        for (int i = 0; i < 12; i++) fq.push_back(i);
        map12 = '0;
    endtask

    initial begin
        logic [15:0] e;
        int r, idx;
        v16 = 0; op16 = 0; a16 = 0; d16 = 0;
        v12 = 0; op12 = 0; a12 = 0; d12 = 0;
        rst16_n = 0; rst12_n = 0;
        model12_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd16", rd16, 16'h0000);
        chk("rst_ae16", {15'b0, ae16}, 16'h0000);
        chk("rst_irq16", {15'b0, irq16}, 16'h0000);
        @(negedge clk);
        rst16_n = 1; rst12_n = 1;

        // ---------- 16-block directed scenarios ----------
        xfer(0, 0, FREE_CNT_ADDR, 0, 16'h0010, "cnt_reset");
        xfer(0, 0, ID_ADDR, 0, 16'hA10C, "id");
        xfer(0, 0, ALLOC_MAP_ADDR, 0, 16'h0000, "map_reset");
        chk("irq_reset", {15'b0, irq16}, 16'h0000);
        xfer(0, 0, 16'h000C, 0, 16'h0000, "unmapped");

        for (int i = 0; i < 3; i++) xfer(0, 0, ALLOC_ADDR, 0, 16'h8000 | 16'(i), "alloc3");
        xfer(0, 0, FREE_CNT_ADDR, 0, 16'd13, "cnt13");
        xfer(0, 0, ALLOC_MAP_ADDR, 0, 16'h0007, "map7");

        for (int i = 3; i < 16; i++) xfer(0, 0, ALLOC_ADDR, 0, 16'h8000 | 16'(i), "alloc_all");
        xfer(0, 0, ALLOC_ADDR, 0, 16'h0000, "alloc_empty_rd");
        chk("ae_set", {15'b0, ae16}, 16'h0001);
        chk("irq_set", {15'b0, irq16}, 16'h0001);
        xfer(0, 0, STATUS_ADDR, 0, 16'h0011, "status_empty");
        xfer(0, 1, STATUS_ADDR, 16'h001C, 0, "w1c");
        xfer(0, 0, STATUS_ADDR, 0, 16'h0001, "status_clr");
        chk("irq_clr", {15'b0, irq16}, 16'h0000);

        xfer(0, 1, FREE_ADDR, 16'd5, 0, "free5");
        xfer(0, 1, FREE_ADDR, 16'd5, 0, "free5_again");
        xfer(0, 0, STATUS_ADDR, 0, 16'h0004, "status_dfree");
        xfer(0, 0, FREE_CNT_ADDR, 0, 16'h0001, "cnt1");
        chk("ae_clr", {15'b0, ae16}, 16'h0000);
        xfer(0, 0, ALLOC_ADDR, 0, 16'h8005, "realloc5");

        xfer(0, 1, STATUS_ADDR, 16'h001C, 0, "w1c2");
        xfer(0, 1, FREE_ADDR, 16'h0010, 0, "free_range");
        xfer(0, 0, STATUS_ADDR, 0, 16'h0009, "status_range");
        xfer(0, 0, FREE_CNT_ADDR, 0, 16'h0000, "cnt_range");
        xfer(0, 0, ALLOC_MAP_ADDR, 0, 16'hFFFF, "map_range");
        idle(0);

        // ---------- 12-block randomized stream ----------
        for (int i = 0; i < 260; i++) begin
            r = $urandom_range(0, 9);
            if (r < 5) begin
                if (fq.size() > 0) begin
                    idx = fq.pop_front();
                    map12[idx] = 1'b1;
                    e = 16'h8000 | 16'(idx);
                end else begin
                    e = 16'h0000;
                end
                xfer(1, 0, ALLOC_ADDR, 0, e, "s_alloc");
            end else if (r < 9) begin
                if (map12 != '0 && $urandom_range(0, 3) != 0) begin
                    do idx = $urandom_range(0, 11); while (!map12[idx]);
                end else begin
                    idx = $urandom_range(0, 15);
                end
                if (idx < 12 && map12[idx]) begin
                    fq.push_back(idx);
                    map12[idx] = 1'b0;
                end
                xfer(1, 1, FREE_ADDR, 16'(idx), 0, "s_free");
            end else begin
                xfer(1, 0, FREE_CNT_ADDR, 0, 16'(fq.size()), "s_cnt");
            end

            if (i == 150) begin
                // Abort mid-cycle right after a read has loaded rd_data
                xfer(1, 0, ALLOC_MAP_ADDR, 0, {4'b0, map12}, "s_map_pre");
                #2;
                rst12_n = 0;
                v12 = 0;
                #1;
                chk("s_rst_rd", rd12, 16'h0000);
                chk("s_rst_ae", {15'b0, ae12}, 16'h0000);
                chk("s_rst_irq", {15'b0, irq12}, 16'h0000);
                @(posedge clk);
                @(negedge clk);
                rst12_n = 1;
                model12_reset();
                xfer(1, 0, FREE_CNT_ADDR, 0, 16'h000C, "s_rst_cnt");
                xfer(1, 0, ALLOC_MAP_ADDR, 0, 16'h0000, "s_rst_map");
                xfer(1, 0, STATUS_ADDR, 0, 16'h0002, "s_rst_status");
            end
        end
        xfer(1, 0, ALLOC_MAP_ADDR, 0, {4'b0, map12}, "s_map_end");
        xfer(1, 0, FREE_CNT_ADDR, 0, 16'(fq.size()), "s_cnt_end");
        while (fq.size() > 0) begin
            idx = fq.pop_front();
            xfer(1, 0, ALLOC_ADDR, 0, 16'h8000 | 16'(idx), "s_drain");
        end
        xfer(1, 0, ALLOC_ADDR, 0, 16'h0000, "s_drain_empty");
        idle(1);
        chk("s_ae_end", {15'b0, ae12}, 16'h0001);
        chk("s_irq_end", {15'b0, irq12}, 16'h0001);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
